// File: rtl/uart_mem_loader.sv
// Host write-command parser: takes 'W',ADDR,DATA,SUM frames from uart_rx,
// writes one word to pattern memory and answers ACK/NAK through uart_tx.
module uart_mem_loader #(
  parameter int AddrBusWidth  = 6,
  parameter int DataBusWidth  = 4,
  parameter int TimeoutCycles = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    rx_break,
  input  logic                    rx_error,
  output logic [AddrBusWidth-1:0] mem_addr,
  output logic                    mem_we,
  output logic [DataBusWidth-1:0] mem_wdata,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    overrun,
  output logic [7:0]              write_count
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_GET_ADDR = 3'd1;
  localparam logic [2:0] ST_GET_DATA = 3'd2;
  localparam logic [2:0] ST_GET_SUM  = 3'd3;
  localparam logic [2:0] ST_WRITE    = 3'd4;
  localparam logic [2:0] ST_RESPOND  = 3'd5;

  localparam logic [7:0] CMD_BYTE = 8'h57;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  // TimeoutCycles-1 always fits in clog2(TimeoutCycles) bits.
  localparam int             TW      = $clog2(TimeoutCycles);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TimeoutCycles - 1);

  logic [2:0]    state_reg, state_next;
  logic [7:0]    addr_reg, data_reg;
  logic [TW-1:0] tmo_reg;
  logic [7:0]    addr_hi_mask, data_hi_mask;

  logic in_frame, abort, accept, timed_out, frame_good, respond_done;

  // Masks select the byte bits that lie above each memory field width.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      assign addr_hi_mask[gi] = (gi >= AddrBusWidth);
      assign data_hi_mask[gi] = (gi >= DataBusWidth);
    end
  endgenerate

  assign in_frame  = (state_reg == ST_GET_ADDR) || (state_reg == ST_GET_DATA) ||
                     (state_reg == ST_GET_SUM);
  assign abort     = in_frame && (rx_break || rx_error);
  assign accept    = in_frame && rx_valid && !abort;
  assign timed_out = in_frame && !abort && !rx_valid && (tmo_reg == TMO_LAST);
  assign frame_good = (rx_data == (CMD_BYTE ^ addr_reg ^ data_reg)) &&
                      ((addr_reg & addr_hi_mask) == 8'h00) &&
                      ((data_reg & data_hi_mask) == 8'h00);
  assign respond_done = (state_reg == ST_RESPOND) && tx_valid && tx_ready;
  assign busy = (state_reg != ST_IDLE);

  always_comb begin
    state_next = state_reg;
    if (abort || timed_out) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:     if (rx_valid && rx_data == CMD_BYTE) state_next = ST_GET_ADDR;
        ST_GET_ADDR: if (accept) state_next = ST_GET_DATA;
        ST_GET_DATA: if (accept) state_next = ST_GET_SUM;
        ST_GET_SUM:  if (accept) state_next = frame_good ? ST_WRITE : ST_RESPOND;
        ST_WRITE:    state_next = ST_RESPOND;
        ST_RESPOND:  if (respond_done) state_next = ST_IDLE;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= 8'h00;
      data_reg    <= 8'h00;
      tmo_reg     <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      overrun     <= 1'b0;
      write_count <= 8'h00;
    end else begin
      state_reg <= state_next;
      mem_we    <= 1'b0;

      // Counter restarts on frame entry and on every accepted byte.
      if ((state_next == ST_GET_ADDR) || (state_next == ST_GET_DATA) ||
          (state_next == ST_GET_SUM)) begin
        if (state_reg == ST_IDLE || accept) tmo_reg <= '0;
        else                               tmo_reg <= tmo_reg + TW'(1);
      end else begin
        tmo_reg <= '0;
      end

      if (accept && state_reg == ST_GET_ADDR) addr_reg <= rx_data;
      if (accept && state_reg == ST_GET_DATA) data_reg <= rx_data;

      if (accept && state_reg == ST_GET_SUM) begin
        if (frame_good) begin
          mem_we      <= 1'b1;
          mem_addr    <= addr_reg[AddrBusWidth-1:0];
          mem_wdata   <= data_reg[DataBusWidth-1:0];
          write_count <= write_count + 8'd1;
        end else begin
          tx_valid <= 1'b1;
          tx_data  <= NAK_BYTE;
        end
      end

      if (state_reg == ST_WRITE) begin
        tx_valid <= 1'b1;
        tx_data  <= ACK_BYTE;
      end

      if (respond_done) tx_valid <= 1'b0;

      if (rx_valid && (state_reg == ST_WRITE || state_reg == ST_RESPOND))
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader: directed protocol cases plus
// randomized frames scored against a frame-level reference model.
module tb_uart_mem_loader;

  localparam int AW = 6;
  localparam int DW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_break = 1'b0;
  logic          rx_error = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          busy;
  logic          overrun;
  logic [7:0]    write_count;

  int total = 0;
  int bad = 0;

  int exp_count = 0;
  int last_addr = 0;
  int last_data = 0;

  int wr_addr_q[$];
  int wr_data_q[$];
  int tx_q[$];

  uart_mem_loader #(
    .AddrBusWidth (AW),
    .DataBusWidth (DW),
    .TimeoutCycles(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_break   (rx_break),
    .rx_error   (rx_error),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .overrun    (overrun),
    .write_count(write_count)
  );

  always #5 clk = ~clk;

  // Observe memory writes and transmitter handshakes mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we === 1'b1) begin
        wr_addr_q.push_back(int'(mem_addr));
        wr_data_q.push_back(int'(mem_wdata));
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_q.push_back(int'(tx_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s: busy=%b still high after %0d cycles, required 0", name, busy, budget);
    end
  endtask

  function automatic bit frame_ok(input int a, input int d, input int s);
    return (s == (8'h57 ^ a ^ d)) && (a < (1 << AW)) && (d < (1 << DW));
  endfunction

  // One full frame with optional backpressure, checked against the model.
  task automatic run_frame(input int a, input int d, input int s, input int gap,
                           input int ready_delay, input string name);
    bit good;
    int exp_resp;
    good = frame_ok(a, d, s);
    exp_resp = good ? 8'h06 : 8'h15;
    clear_obs();
    tx_ready = (ready_delay == 0);
    send_byte(8'h57, gap);
    send_byte(8'(a), gap);
    send_byte(8'(d), gap);
    send_byte(8'(s), 0);
    repeat (ready_delay) tick();
    tx_ready = 1'b1;
    wait_idle(200, name);
    if (good) begin
      exp_count = (exp_count + 1) % 256;
      last_addr = a;
      last_data = d;
    end
    $display("frame %s: addr=%02h data=%02h sum=%02h -> expect resp=%02h writes=%0d count=%0d",
             name, a, d, s, exp_resp, good, exp_count);
    total++;
    if (tx_q.size() != 1 || tx_q[0] != exp_resp) begin
      bad++;
      $display("FAIL %s resp: got %0d bytes first=%02h, required 1 byte %02h",
               name, tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : -1, exp_resp);
    end
    total++;
    if (wr_addr_q.size() != int'(good)) begin
      bad++;
      $display("FAIL %s write pulses: got %0d, required %0d", name, wr_addr_q.size(), good);
    end else if (good && (wr_addr_q[0] != a || wr_data_q[0] != d)) begin
      bad++;
      $display("FAIL %s write content: got addr=%0h data=%0h, required addr=%0h data=%0h",
               name, wr_addr_q[0], wr_data_q[0], a, d);
    end
    total++;
    if (write_count !== 8'(exp_count) || mem_addr !== AW'(last_addr) ||
        mem_wdata !== DW'(last_data) || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL %s post-state: count=%0d addr=%0h data=%0h we=%b, required %0d %0h %0h 0",
               name, write_count, mem_addr, mem_wdata, mem_we, exp_count, last_addr, last_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if (mem_addr !== '0 || mem_we !== 1'b0 || mem_wdata !== '0 || tx_data !== 8'h00 ||
        tx_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || write_count !== 8'h00) begin
      bad++;
      $display("FAIL reset: addr=%0h we=%b wdata=%0h tx=%02h txv=%b busy=%b ovr=%b cnt=%0d, required all 0",
               mem_addr, mem_we, mem_wdata, tx_data, tx_valid, busy, overrun, write_count);
    end
    rst = 1'b0;
    tick();
    exp_count = 0;
    last_addr = 0;
    last_data = 0;
  endtask

  task automatic test_ack();
    clear_obs();
    tx_ready = 1'b1;
    send_byte(8'h57, 2);
    send_byte(8'h05, 2);
    send_byte(8'h0A, 2);
    send_byte(8'h58, 0);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== AW'(5) || mem_wdata !== DW'(10) || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL ack write cycle: we=%b addr=%0h wdata=%0h txv=%b, required 1 5 a 0",
               mem_we, mem_addr, mem_wdata, tx_valid);
    end
    tick();
    total++;
    if (mem_we !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h06) begin
      bad++;
      $display("FAIL ack respond cycle: we=%b txv=%b tx=%02h, required 0 1 06", mem_we, tx_valid, tx_data);
    end
    tick();
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || write_count !== 8'd1 ||
        tx_q.size() != 1 || wr_addr_q.size() != 1) begin
      bad++;
      $display("FAIL ack done: txv=%b busy=%b cnt=%0d tx=%0d writes=%0d, required 0 0 1 1 1",
               tx_valid, busy, write_count, tx_q.size(), wr_addr_q.size());
    end
    $display("frame ack: addr=05 data=0a sum=58 -> resp=06 count=1");
    exp_count = 1;
    last_addr = 5;
    last_data = 10;
  endtask

  task automatic test_nak();
    clear_obs();
    send_byte(8'h57, 1);
    send_byte(8'h05, 1);
    send_byte(8'h0A, 1);
    send_byte(8'h59, 0);
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h15 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL nak latency: txv=%b tx=%02h we=%b, required 1 15 0", tx_valid, tx_data, mem_we);
    end
    wait_idle(20, "nak_idle");
    $display("frame nak_sum: addr=05 data=0a sum=59 -> resp=15");
    run_frame(8'h05, 8'h0A, 8'h59, 2, 3, "nak_sum");
    run_frame(8'h40, 8'h01, 8'h16, 2, 0, "nak_addr_range");
    run_frame(8'h03, 8'h10, 8'h44, 1, 0, "nak_data_range");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int a, d, s;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 63));
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : (8'h57 ^ a ^ d);
      run_frame(a, d, s, int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
                $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      run_frame(8'(i * 9), 8'(i + 3), 8'h57 ^ 8'(i * 9) ^ 8'(i + 3), 0, 0, $sformatf("b2b%0d", i));
    end
  endtask

  task automatic test_backpressure();
    bit stable = 1'b1;
    clear_obs();
    tx_ready = 1'b0;
    send_byte(8'h57, 1);
    send_byte(8'h21, 1);
    send_byte(8'h07, 1);
    send_byte(8'h71, 0);
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL bp overrun before: got %b, required 0", overrun);
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        rx_data  = 8'h57;
        rx_valid = 1'b1;
      end
      tick();
      rx_valid = 1'b0;
      if (tx_valid !== 1'b1 || tx_data !== 8'h06) stable = 1'b0;
    end
    total++;
    if (!stable || overrun !== 1'b1 || tx_q.size() != 0) begin
      bad++;
      $display("FAIL bp hold: stable=%b overrun=%b transfers=%0d, required 1 1 0",
               stable, overrun, tx_q.size());
    end
    tx_ready = 1'b1;
    tick();
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_q.size() != 1 || wr_addr_q.size() != 1) begin
      bad++;
      $display("FAIL bp release: txv=%b busy=%b transfers=%0d writes=%0d, required 0 0 1 1",
               tx_valid, busy, tx_q.size(), wr_addr_q.size());
    end
    exp_count = (exp_count + 1) % 256;
    last_addr = 8'h21;
    last_data = 8'h07;
    $display("frame backpressure: addr=21 data=07 sum=71 -> resp=06 overrun=1");
  endtask

  task automatic test_abort_error();
    clear_obs();
    send_byte(8'h57, 1);
    send_byte(8'h05, 1);
    rx_error = 1'b1;
    send_byte(8'h0A, 0);
    rx_error = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_error: busy=%b, required 0", busy);
    end
    send_byte(8'h58, 10);
    total++;
    if (tx_q.size() != 0 || wr_addr_q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_error quiet: transfers=%0d writes=%0d busy=%b, required 0 0 0",
               tx_q.size(), wr_addr_q.size(), busy);
    end
    $display("frame abort_error: aborted after ADDR");
    run_frame(8'h11, 8'h02, 8'h57 ^ 8'h11 ^ 8'h02, 1, 0, "after_error");
  endtask

  task automatic test_timeout();
    clear_obs();
    send_byte(8'h57, 1);
    send_byte(8'h05, 1);
    send_byte(8'h0A, TO - 1);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout early: busy=%b after %0d idle cycles, required 1", busy, TO - 1);
    end
    tick();
    total++;
    if (busy !== 1'b0 || tx_q.size() != 0 || wr_addr_q.size() != 0) begin
      bad++;
      $display("FAIL timeout: busy=%b transfers=%0d writes=%0d, required 0 0 0",
               busy, tx_q.size(), wr_addr_q.size());
    end
    $display("frame timeout: gap of %0d cycles after DATA", TO);
    run_frame(8'h22, 8'h0C, 8'h57 ^ 8'h22 ^ 8'h0C, 2, 0, "after_timeout");
    // Byte arriving on the very last allowed cycle still completes the frame.
    run_frame(8'h3F, 8'h0F, 8'h57 ^ 8'h3F ^ 8'h0F, TO - 1, 0, "timeout_edge");
  endtask

  task automatic test_garbage();
    int bytes[3] = '{8'h00, 8'hFF, 8'h06};
    bit quiet = 1'b1;
    clear_obs();
    foreach (bytes[i]) begin
      send_byte(8'(bytes[i]), 0);
      if (busy !== 1'b0) quiet = 1'b0;
    end
    repeat (4) tick();
    total++;
    if (!quiet || tx_q.size() != 0 || wr_addr_q.size() != 0) begin
      bad++;
      $display("FAIL garbage: quiet=%b transfers=%0d writes=%0d, required 1 0 0",
               quiet, tx_q.size(), wr_addr_q.size());
    end
    $display("garbage: 00 ff 06 ignored");
  endtask

  task automatic test_reset_mid();
    send_byte(8'h57, 1);
    send_byte(8'h05, 1);
    rst = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        tx_valid !== 1'b0 || tx_data !== 8'h00 || overrun !== 1'b0 || write_count !== 8'h00) begin
      bad++;
      $display("FAIL reset_get_data: busy=%b we=%b addr=%0h wdata=%0h txv=%b tx=%02h ovr=%b cnt=%0d, required all 0",
               busy, mem_we, mem_addr, mem_wdata, tx_valid, tx_data, overrun, write_count);
    end
    rst = 1'b0;
    tick();
    tx_ready = 1'b0;
    send_byte(8'h57, 1);
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    send_byte(8'h54, 3);
    rst = 1'b1;
    tick();
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || write_count !== 8'h00 || mem_addr !== '0 ||
        tx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_respond: txv=%b busy=%b cnt=%0d addr=%0h tx=%02h, required 0 0 0 0 00",
               tx_valid, busy, write_count, mem_addr, tx_data);
    end
    rst = 1'b0;
    tx_ready = 1'b1;
    exp_count = 0;
    last_addr = 0;
    last_data = 0;
    clear_obs();
    repeat (3) tick();
    $display("reset mid-frame and mid-response");
    run_frame(8'h2A, 8'h09, 8'h57 ^ 8'h2A ^ 8'h09, 1, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_ack();
    test_nak();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_abort_error();
    test_timeout();
    test_garbage();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
